// File: rtl/gost_pkg.sv
// gost_pkg: shared definitions for the GOST 28147-89 block engine.
//   SBOX      : substitution tables, row i applies to nibble [31-4i:28-4i]
//   ROUNDS    : Feistel rounds per block
//   state_t   : engine FSM states
//   key_sel   : key index (1..8) used by round rc (0-based) for a direction
//   key_word  : extracts subkey K1..K8 from the 256-bit key
//   rotl11    : 32-bit rotate left by 11
package gost_pkg;

   localparam int ROUNDS = 32;

   localparam logic [3:0] SBOX [0:7][0:15] = '{
      '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9, 4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1},
      '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
      '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD, 4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
      '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6, 4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
      '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD, 4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
      '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA, 4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
      '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC, 4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
      '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3, 4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2}
   };

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Forward runs (encrypt rounds 0..23, decrypt rounds 0..7) walk K1..K8;
   // every other round walks K8..K1.
   function automatic logic [3:0] key_sel(input logic [5:0] rc, input logic decrypt);
      logic forward;
      forward = decrypt ? (rc < 6'd8) : (rc < 6'd24);
      if (forward)
         return {1'b0, rc[2:0]} + 4'd1;
      else
         return 4'd8 - {1'b0, rc[2:0]};
   endfunction

   function automatic logic [31:0] key_word(input logic [255:0] key, input logic [3:0] idx);
      return key[(8 - int'(idx)) * 32 +: 32];
   endfunction

   function automatic logic [31:0] rotl11(input logic [31:0] a);
      return {a[20:0], a[31:21]};
   endfunction

endpackage

// File: rtl/gost_round.sv
// gost_round: one combinational GOST Feistel round.
//   l, r      : current halves
//   k         : 32-bit subkey for this round
//   l_next    : r ^ rotl11(S(mix(l, k)))
//   r_next    : l
//   ADD_MODE  : 0 = XOR key mixing, 1 = modulo-2^32 addition
module gost_round
   import gost_pkg::*;
#(
   parameter int ADD_MODE = 0
) (
   input  logic [31:0] l,
   input  logic [31:0] r,
   input  logic [31:0] k,
   output logic [31:0] l_next,
   output logic [31:0] r_next
);

   logic [31:0] mixed;
   logic [31:0] subst;

   always_comb begin
      mixed = (ADD_MODE != 0) ? (l + k) : (l ^ k);
      subst = '0;
      for (int i = 0; i < 8; i++)
         subst[28 - 4 * i +: 4] = SBOX[i][mixed[28 - 4 * i +: 4]];
   end

   assign l_next = r ^ rotl11(subst);
   assign r_next = l;

endmodule

// File: rtl/gost_block_engine.sv
// gost_block_engine: iterative GOST 28147-89 64-bit block cipher core.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : request handshake; in_key, in_block, in_decrypt latched on accept
//   out_valid/out_ready : result handshake; out_block held stable while out_valid
//   busy              : high while a block is being processed or awaiting pickup
//   ROUNDS_PER_CYCLE  : 1, 2, 4 or 8 rounds evaluated per clock
//   ADD_MODE          : key mixing, 0 = XOR, 1 = addition
module gost_block_engine
   import gost_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter int ADD_MODE         = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_decrypt,
   input  logic [255:0] in_key,
   input  logic [63:0]  in_block,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [63:0]  out_block,
   output logic         busy
);

   localparam int RPC = ROUNDS_PER_CYCLE;

   if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8) begin : g_bad_rpc
      $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
   end

   state_t        state, state_next;
   logic [5:0]    rc;
   logic [5:0]    rc_next;
   logic          last_step;
   logic [255:0]  key_q;
   logic [31:0]   l_q, r_q;
   logic          dec_q;
   logic [63:0]   out_block_q;
   logic [31:0]   l_chain [0:RPC];
   logic [31:0]   r_chain [0:RPC];

   assign rc_next   = rc + 6'(RPC);
   assign last_step = (rc_next == 6'(ROUNDS));

   // Unrolled round chain; each stage picks its subkey from its absolute round number.
   assign l_chain[0] = l_q;
   assign r_chain[0] = r_q;

   for (genvar j = 0; j < RPC; j++) begin : g_round
      logic [31:0] k;
      assign k = key_word(key_q, key_sel(rc + 6'(j), dec_q));
      gost_round #(.ADD_MODE(ADD_MODE)) u_round (
         .l      (l_chain[j]),
         .r      (r_chain[j]),
         .k      (k),
         .l_next (l_chain[j + 1]),
         .r_next (r_chain[j + 1])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = RUN;
         RUN:     if (last_step) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rc          <= '0;
         key_q       <= '0;
         l_q         <= '0;
         r_q         <= '0;
         dec_q       <= 1'b0;
         out_block_q <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               key_q <= in_key;
               l_q   <= in_block[63:32];
               r_q   <= in_block[31:0];
               dec_q <= in_decrypt;
               rc    <= '0;
            end
            RUN: begin
               l_q <= l_chain[RPC];
               r_q <= r_chain[RPC];
               rc  <= rc_next;
               // Final output swaps the halves.
               if (last_step)
                  out_block_q <= {r_chain[RPC], l_chain[RPC]};
            end
            DONE: if (out_ready) key_q <= '0;
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_block = out_block_q;

endmodule
